// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache with 4-word line refill (option: ICACHE_CRITICAL_WORD_EN)
module icache_direct #(
    parameter int NUM_LINES = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic [31:0]  proc_rdata,
    output logic         proc_stall,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
);

    localparam int IW = $clog2(NUM_LINES);
    localparam int TW = 28 - IW;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t               state;
    logic [NUM_LINES-1:0] valid;
    logic [TW-1:0]        tag_mem  [NUM_LINES];
    logic [127:0]         data_mem [NUM_LINES];

    logic [IW-1:0] req_idx;
    logic [TW-1:0] req_tag;
    logic [IW-1:0] fill_idx;
    logic [TW-1:0] fill_tag;
    logic          hit;
    logic          fill_done;

    // Writes and write data are meaningless for a read-only cache.
    logic unused_inputs;
    assign unused_inputs = ^{proc_write, proc_wdata};

    assign mem_write = 1'b0;
    assign mem_wdata = '0;

    assign req_idx = proc_addr[IW+1:2];
    assign req_tag = proc_addr[29:IW+2];

    // The registered line address doubles as the refill target, so the fill
    // never depends on what the fetch stage drives during FETCH.
    assign fill_idx = mem_addr[IW-1:0];
    assign fill_tag = mem_addr[27:IW];

    assign hit       = (state == IDLE) && proc_read && valid[req_idx]
                       && (tag_mem[req_idx] == req_tag);
    assign fill_done = (state == FETCH) && mem_ready;

    function automatic logic [31:0] word_sel(input logic [127:0] line,
                                             input logic [1:0]   off);
        return line[32*off +: 32];
    endfunction

    // Stall and read data are combinational from state, arrays and request.
    always_comb begin
        proc_stall = 1'b0;
        proc_rdata = '0;
        case (state)
            IDLE: begin
                if (proc_read) begin
                    if (hit) begin
                        proc_rdata = word_sel(data_mem[req_idx], proc_addr[1:0]);
                    end else begin
                        proc_stall = 1'b1;
                    end
                end
            end
            FETCH: begin
                proc_stall = 1'b1;
`ifdef ICACHE_CRITICAL_WORD_EN
                if (mem_ready) begin
                    proc_stall = 1'b0;
                    proc_rdata = word_sel(mem_rdata, proc_addr[1:0]);
                end
`endif
            end
            default: begin
                proc_stall = 1'b0;
            end
        endcase
    end

    // Control FSM: miss detection, memory request and valid-bit update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mem_read <= 1'b0;
            mem_addr <= '0;
            valid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (proc_read && !hit) begin
                        mem_addr <= proc_addr[29:2];
                        mem_read <= 1'b1;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        valid[fill_idx] <= 1'b1;
                        mem_read        <= 1'b0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_read <= 1'b0;
                end
            endcase
        end
    end

    // Tag and data arrays are not reset; valid bits alone gate their use.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - directed table-driven testbench for icache_direct
module tb_icache_direct;

    logic         clk;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    int checks;
    int failures;

`ifdef ICACHE_CRITICAL_WORD_EN
    localparam bit CW = 1'b1;
`else
    localparam bit CW = 1'b0;
`endif

    localparam logic [127:0] L1 = 128'h4444_4444_3333_3333_2222_2222_1111_1111;
    localparam logic [127:0] L2 = 128'hDDDD_DDDD_CCCC_CCCC_BBBB_BBBB_AAAA_AAAA;
    localparam logic [127:0] L3 = 128'h8888_8888_7777_7777_6666_6666_5555_5555;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [29:0]  addr;
        logic         rdy;
        logic [127:0] mdata;
        logic         e_stall;
        logic [31:0]  e_rdata;
        logic         e_mread;
        logic [27:0]  e_maddr;
    } vec_t;

    vec_t vecs[$];

    icache_direct #(.NUM_LINES(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_rdata (proc_rdata),
        .proc_stall (proc_stall),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_stall, input logic [31:0] e_rdata,
                                 input logic e_mread, input logic [27:0] e_maddr);
        check({tag, " proc_stall"}, 128'(proc_stall), 128'(e_stall));
        check({tag, " proc_rdata"}, 128'(proc_rdata), 128'(e_rdata));
        check({tag, " mem_read"},   128'(mem_read),   128'(e_mread));
        check({tag, " mem_addr"},   128'(mem_addr),   128'(e_maddr));
        check({tag, " mem_write"},  128'(mem_write),  128'(0));
        check({tag, " mem_wdata"},  mem_wdata,        128'(0));
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [29:0] addr,
                         input logic rdy, input logic [127:0] mdata);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = addr;
        mem_ready  = rdy;
        mem_rdata  = mdata;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        proc_wdata = 32'hDEAD_BEEF;
        drive(1'b0, 1'b0, 30'h0, 1'b0, '0);

        // Reset state: idle with no request, then a request must stall.
        @(negedge clk);
        #2;
        check_outputs("reset_idle", 1'b0, 32'h0, 1'b0, 28'h0);
        proc_read = 1'b1;
        proc_addr = 30'h5;
        #1;
        check("reset_read proc_stall", 128'(proc_stall), 128'(1));
        @(negedge clk);
        drive(1'b0, 1'b0, 30'h0, 1'b0, '0);
        rst_n = 1'b1;

        // Cold miss of 0x5 with mem_ready after 3 cycles, then same-line hits.
        vecs.push_back('{1'b1, 1'b0, 30'h5,  1'b0, '0, 1'b1, 32'h0, 1'b0, 28'h0});
        vecs.push_back('{1'b1, 1'b0, 30'h5,  1'b0, '0, 1'b1, 32'h0, 1'b1, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h5,  1'b0, '0, 1'b1, 32'h0, 1'b1, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h5,  1'b1, L1, !CW, CW ? 32'h2222_2222 : 32'h0, 1'b1, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h5,  1'b0, '0, 1'b0, 32'h2222_2222, 1'b0, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h4,  1'b0, '0, 1'b0, 32'h1111_1111, 1'b0, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h6,  1'b0, '0, 1'b0, 32'h3333_3333, 1'b0, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h7,  1'b0, '0, 1'b0, 32'h4444_4444, 1'b0, 28'h1});
        // Write-only and idle cycles with stray mem_ready: no effect.
        vecs.push_back('{1'b0, 1'b1, 30'h24, 1'b1, L2, 1'b0, 32'h0, 1'b0, 28'h1});
        vecs.push_back('{1'b0, 1'b1, 30'h8,  1'b1, L2, 1'b0, 32'h0, 1'b0, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h4,  1'b0, '0, 1'b0, 32'h1111_1111, 1'b0, 28'h1});
        vecs.push_back('{1'b1, 1'b1, 30'h5,  1'b1, L2, 1'b0, 32'h2222_2222, 1'b0, 28'h1});
        // Conflict: 0x24 evicts line 1, mem_ready after 2 cycles.
        vecs.push_back('{1'b1, 1'b0, 30'h24, 1'b0, '0, 1'b1, 32'h0, 1'b0, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h24, 1'b0, '0, 1'b1, 32'h0, 1'b1, 28'h9});
        vecs.push_back('{1'b1, 1'b0, 30'h24, 1'b1, L2, !CW, CW ? 32'hAAAA_AAAA : 32'h0, 1'b1, 28'h9});
        vecs.push_back('{1'b1, 1'b0, 30'h24, 1'b0, '0, 1'b0, 32'hAAAA_AAAA, 1'b0, 28'h9});
        // 0x4 now misses and is refilled.
        vecs.push_back('{1'b1, 1'b0, 30'h4,  1'b0, '0, 1'b1, 32'h0, 1'b0, 28'h9});
        vecs.push_back('{1'b1, 1'b0, 30'h4,  1'b0, '0, 1'b1, 32'h0, 1'b1, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h4,  1'b1, L1, !CW, CW ? 32'h1111_1111 : 32'h0, 1'b1, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h4,  1'b0, '0, 1'b0, 32'h1111_1111, 1'b0, 28'h1});
        vecs.push_back('{1'b1, 1'b0, 30'h7,  1'b0, '0, 1'b0, 32'h4444_4444, 1'b0, 28'h1});

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].rdy, vecs[i].mdata);
            #2;
            check_outputs($sformatf("row%0d", i), vecs[i].e_stall, vecs[i].e_rdata,
                          vecs[i].e_mread, vecs[i].e_maddr);
            @(negedge clk);
        end

        // Reset mid-refill: miss on 0x10, abort during FETCH.
        drive(1'b1, 1'b0, 30'h10, 1'b0, '0);
        #2;
        check_outputs("rst_miss", 1'b1, 32'h0, 1'b0, 28'h1);
        @(negedge clk);
        #2;
        check_outputs("rst_fetch", 1'b1, 32'h0, 1'b1, 28'h4);
        rst_n = 1'b0;
        #1;
        check_outputs("rst_abort", 1'b1, 32'h0, 1'b0, 28'h0);
        mem_ready = 1'b1;
        mem_rdata = L3;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 30'h10, 1'b0, '0);
        #2;
        check_outputs("rst_remiss", 1'b1, 32'h0, 1'b0, 28'h0);
        @(negedge clk);
        drive(1'b1, 1'b0, 30'h10, 1'b1, L3);
        #2;
        check_outputs("rst_refill", !CW, CW ? 32'h5555_5555 : 32'h0, 1'b1, 28'h4);
        @(negedge clk);
        drive(1'b1, 1'b0, 30'h11, 1'b0, '0);
        #2;
        check_outputs("rst_hit", 1'b0, 32'h6666_6666, 1'b0, 28'h4);
        @(negedge clk);
        drive(1'b1, 1'b0, 30'h5, 1'b0, '0);
        #2;
        check_outputs("rst_lost_line", 1'b1, 32'h0, 1'b0, 28'h4);
        @(negedge clk);
        drive(1'b0, 1'b0, 30'h0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache that sits between the fetch-side realigner and the slow main-memory port. It answers the fetch stage's word requests (`ICACHE_*` side) and hides miss latency with `proc_stall`. On a miss it performs a 4-word line refill from memory. The fetch stage holds its address stable until `proc_stall` drops.

## Interface
- `NUM_LINES`, default 8: number of cache lines; power of two, 2..256. Index width is `IW = log2(NUM_LINES)`, tag width is `28-IW`.
- `clk  in  1`: clock, rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `proc_read  in  1`: fetch read request.
- `proc_write  in  1`: write request; ignored by this read-only cache.
- `proc_addr  in  30`: word address. Bits [1:0] are the word offset, [IW+1:2] the index, [29:IW+2] the tag.
- `proc_wdata  in  32`: unused; kept so the port list matches the processor-side interface.
- `proc_rdata  out  32`: returned instruction word.
- `proc_stall  out  1`: request not yet satisfied.
- `mem_read  out  1`: line read request to memory.
- `mem_write  out  1`: constant 0.
- `mem_addr  out  28`: line address, equal to `proc_addr[29:2]`.
- `mem_wdata  out  128`: constant 0.
- `mem_rdata  in  128`: refill line. Word k is `[32k+31:32k]`.
- `mem_ready  in  1`: memory response valid for one cycle.

## Operation
- Storage per line: valid bit, tag, 128-bit data. Only the valid bits are reset; tag and data arrays are not reset.
- The state machine has two states, IDLE and FETCH.
- **IDLE**
  - Hit (`proc_read` high, valid set, tag match): `proc_stall=0`. `proc_rdata` returns the selected word combinationally. Stay in IDLE.
  - Miss (`proc_read` high and not a hit): `proc_stall=1` in the same cycle. Latch `proc_addr[29:2]` into `mem_addr` and set `mem_read=1`. Go to FETCH.
  - `proc_read` low: `proc_stall=0` and `proc_rdata=0`. `proc_write` alone behaves the same; `proc_write` together with `proc_read` is treated as a plain read.
- **FETCH**
  - `mem_read` stays high and `proc_stall=1` until `mem_ready` is sampled high.
  - On the `mem_ready` edge:
    - write `mem_rdata` into the line at the latched index;
    - set valid and write the tag;
    - clear `mem_read`;
    - return to IDLE.
  - The refill uses the latched address only. A change of `proc_addr` during FETCH is a protocol violation; behaviour is undefined apart from the latched line being filled.
- `mem_ready` seen while in IDLE is ignored.
- Refilling a valid line overwrites it; there is no writeback.

## Timing
- Reset values: IDLE, all valid bits 0, `mem_read=0`, `mem_addr=0`. `proc_stall` is 1 only if `proc_read` is asserted (every access misses after reset). `proc_rdata=0` when not hitting. `mem_write=0`, `mem_wdata=0`.
- Asynchronous reset asserted during FETCH aborts the refill immediately: `mem_read` drops, no line is written, and the next access misses.
- Hit latency: 0 cycles (same-cycle data, no stall).
- Miss, `mem_ready` arriving N cycles after `mem_read` rises:
  - cycle 0: miss detected, stall;
  - cycles 1..N: FETCH;
  - cycle N+1: IDLE hit, stall 0.
- Miss penalty is N+1 stall cycles.
- `mem_read` and `mem_addr` are registered outputs. `proc_stall` and `proc_rdata` are combinational from state and arrays.

## Configuration
- `ICACHE_CRITICAL_WORD_EN` defined: in the FETCH cycle where `mem_ready=1`:
  - `proc_stall=0`;
  - `proc_rdata = mem_rdata` word at `proc_addr[1:0]`.
  - The fetch stage advances that same cycle, so the miss penalty is N cycles.
- Undefined: `proc_stall` stays 1 through the `mem_ready` cycle and the data is delivered by the IDLE hit in the following cycle.

## Test plan
- **Cold miss then hit.** Reset, `NUM_LINES=8`, `proc_read=1`, `proc_addr=30'h0000_0005`. Memory returns `128'h4444_4444_3333_3333_2222_2222_1111_1111` after 3 cycles. Required: `mem_addr=28'h1`, `mem_read` high for 3 cycles, stall for 4 cycles, then `proc_rdata=32'h2222_2222` with stall 0.
- **Same-line hits.** After the test above, addresses `30'h4`, `30'h6` and `30'h7` give `1111_1111`, `3333_3333` and `4444_4444`, each with stall 0 and `mem_read` 0.
- **Conflict eviction.** Access `30'h4`, then `30'h24` (same index 1, different tag). Required: a miss with `mem_addr=28'h9`. Afterwards, `30'h4` misses again.
- **Idle and write.** With `proc_read=0` and `proc_write=1`: stall 0, `mem_read` 0, `mem_write` 0, no state change, and memory `mem_ready` pulses are ignored.
- **Reset mid-refill.** Pull `rst_n` low during FETCH. Required: `mem_read` drops immediately. After release, the same address misses again.
- **Critical-word forwarding.** With `ICACHE_CRITICAL_WORD_EN` defined and the first scenario repeated, `proc_stall=0` and `proc_rdata=32'h2222_2222` in the `mem_ready` cycle (3 stall cycles total).
